// File: rtl/game_pkg.sv
// Shared game constants, joystick decode and shot FSM encoding.
// Imported by the player motion block and its tick divider.
package game_pkg;

  localparam int SCR_MIN_COL   = 5;
  localparam int SCR_MAX_COL   = 635;
  localparam int DEF_START_ROW = 350;
  localparam int DEF_START_COL = 310;

  localparam logic [3:0] JOY_LEFT_TH  = 4'd4;
  localparam logic [3:0] JOY_RIGHT_TH = 4'd6;

  typedef enum logic [1:0] {
    SHOT_IDLE = 2'd0,
    SHOT_REQ  = 2'd1,
    SHOT_COOL = 2'd2
  } shot_state_t;

  typedef enum logic [1:0] {
    DIR_HOLD  = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_RIGHT = 2'd2
  } dir_t;

  function automatic dir_t joy_dir(input logic [3:0] joy);
    dir_t d;
    d = DIR_HOLD;
    if (joy > JOY_RIGHT_TH) d = DIR_RIGHT;
    else if (joy < JOY_LEFT_TH) d = DIR_LEFT;
    return d;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Enable-gated modulo-DIV counter producing a one-cycle tick.
// Sync clear has priority over counting.
module tick_gen
  import game_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic En_i,
  input  logic Clr_i,
  output logic Tick_o
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt_q;

  assign Tick_o = En_i && (cnt_q == CW'(DIV - 1));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
    end else if (Clr_i || Tick_o) begin
      cnt_q <= '0;
    end else if (En_i) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/player_motion.sv
// Player column motion with clamping and a shot request handshake
// gated by a cooldown measured in move ticks.
module player_motion
  import game_pkg::*;
#(
  parameter int ROW_W     = 9,
  parameter int COL_W     = 10,
  parameter int START_ROW = DEF_START_ROW,
  parameter int START_COL = DEF_START_COL,
  parameter int MIN_COL   = SCR_MIN_COL,
  parameter int MAX_COL   = SCR_MAX_COL,
  parameter int STEP      = 5,
  parameter int TICK_DIV  = 833333,
  parameter int COOLDOWN  = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Enable,
  input  logic [3:0]       Joystick_data,
  input  logic             Fire,
  input  logic             Respawn,
  input  logic             Shot_Ack,
  output logic [ROW_W-1:0] Player_Row,
  output logic [COL_W-1:0] Player_Col,
  output logic             Shot_Req,
  output logic [COL_W-1:0] Shot_Col
);

  localparam int KW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

  logic             tick;
  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;
  logic [COL_W-1:0] col_d;
  logic [COL_W:0]   sum_r;
  shot_state_t      st_q;
  logic [KW-1:0]    cool_q;
  logic             req_q;
  logic [COL_W-1:0] scol_q;

  tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick (
    .Clk    (Clk),
    .Reset  (Reset),
    .En_i   (Enable),
    .Clr_i  (Respawn),
    .Tick_o (tick)
  );

  // Widened by one bit so the right-edge compare cannot overflow.
  assign sum_r = {1'b0, col_q} + (COL_W+1)'(STEP);

  always_comb begin
    col_d = col_q;
    unique case (joy_dir(Joystick_data))
      DIR_RIGHT:
        col_d = (sum_r > (COL_W+1)'(MAX_COL)) ?
                COL_W'(MAX_COL) : sum_r[COL_W-1:0];
      DIR_LEFT:
        col_d = ({1'b0, col_q} < (COL_W+1)'(MIN_COL + STEP)) ?
                COL_W'(MIN_COL) : col_q - COL_W'(STEP);
      default:
        col_d = col_q;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      row_q <= ROW_W'(START_ROW);
      col_q <= COL_W'(START_COL);
    end else begin
      row_q <= ROW_W'(START_ROW);
      if (Respawn) col_q <= COL_W'(START_COL);
      else if (tick) col_q <= col_d;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      st_q   <= SHOT_IDLE;
      cool_q <= '0;
      req_q  <= 1'b0;
      scol_q <= '0;
    end else if (Respawn) begin
      st_q   <= SHOT_IDLE;
      cool_q <= '0;
      req_q  <= 1'b0;
    end else begin
      unique case (st_q)
        SHOT_IDLE: begin
          if (Fire && Enable) begin
            st_q   <= SHOT_REQ;
            req_q  <= 1'b1;
            scol_q <= col_q;
          end
        end
        SHOT_REQ: begin
          if (Shot_Ack) begin
            st_q   <= SHOT_COOL;
            req_q  <= 1'b0;
            cool_q <= '0;
          end
        end
        SHOT_COOL: begin
          if (tick) begin
            if (cool_q == KW'(COOLDOWN - 1)) begin
              st_q   <= SHOT_IDLE;
              cool_q <= '0;
            end else begin
              cool_q <= cool_q + KW'(1);
            end
          end
        end
        default: begin
          st_q  <= SHOT_IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  assign Player_Row = row_q;
  assign Player_Col = col_q;
  assign Shot_Req   = req_q;
  assign Shot_Col   = scol_q;

endmodule

// File: tb/tb_player_motion.sv
// Directed bench for player_motion; shot requests are checked by a
// queue-driven monitor, positions by direct comparison.
module tb_player_motion;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Enable;
  logic [3:0] joy;
  logic [3:0] joy2;
  logic       Fire;
  logic       Respawn;
  logic       Ack;

  logic [8:0] row;
  logic [9:0] col;
  logic       req;
  logic [9:0] scol;
  logic [8:0] row2;
  logic [9:0] col2;
  logic       req2;
  logic [9:0] scol2;
  logic       fire2 = 1'b0;
  logic       ack2 = 1'b0;

  typedef struct {
    int col;
    int len;
  } exp_t;

  exp_t exq[$];
  int   total = 0;
  int   bad   = 0;

  always #5 Clk = ~Clk;

  player_motion #(
    .TICK_DIV (4),
    .COOLDOWN (2)
  ) u_dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .Enable        (Enable),
    .Joystick_data (joy),
    .Fire          (Fire),
    .Respawn       (Respawn),
    .Shot_Ack      (Ack),
    .Player_Row    (row),
    .Player_Col    (col),
    .Shot_Req      (req),
    .Shot_Col      (scol)
  );

  player_motion #(
    .START_COL (8),
    .TICK_DIV  (4),
    .COOLDOWN  (2)
  ) u_dut2 (
    .Clk           (Clk),
    .Reset         (Reset),
    .Enable        (Enable),
    .Joystick_data (joy2),
    .Fire          (fire2),
    .Respawn       (Respawn),
    .Shot_Ack      (ack2),
    .Player_Row    (row2),
    .Player_Col    (col2),
    .Shot_Req      (req2),
    .Shot_Col      (scol2)
  );

  function automatic void chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  bit   mon_act = 1'b0;
  int   mon_n   = 0;
  exp_t cur;

  always @(negedge Clk) begin
    if (req) begin
      if (!mon_act) begin
        mon_act = 1'b1;
        mon_n   = 1;
        if (exq.size() == 0) begin
          chk("shot_unexpected", 1, 0);
          cur = '{int'(scol), 0};
        end else begin
          cur = exq.pop_front();
          chk("shot_col", int'(scol), cur.col);
        end
      end else begin
        mon_n++;
        chk("shot_col_hold", int'(scol), cur.col);
      end
    end else if (mon_act) begin
      mon_act = 1'b0;
      if (cur.len != 0) chk("shot_len", mon_n, cur.len);
    end
  end

  initial begin
    Reset = 1'b1; Enable = 1'b0; joy = 4'd5; joy2 = 4'd5;
    Fire = 1'b0; Respawn = 1'b0; Ack = 1'b0;
    #12;
    chk("rst_row", int'(row), 350);
    chk("rst_col", int'(col), 310);
    chk("rst_req", int'(req), 0);
    chk("rst_scol", int'(scol), 0);
    chk("rst_col2", int'(col2), 8);
    @(negedge Clk);
    Reset = 1'b0;
    step(1);

    Enable = 1'b1; joy = 4'd9;
    step(4); chk("right_1", int'(col), 315);
    step(4); chk("right_2", int'(col), 320);
    chk("dead_col2", int'(col2), 8);
    step(280); chk("right_sat", int'(col), 635);
    step(8); chk("right_hold", int'(col), 635);
    chk("row_const", int'(row), 350);

    joy = 4'd5; joy2 = 4'd0;
    step(4); chk("left_clamp", int'(col2), 5);
    step(8); chk("left_hold", int'(col2), 5);
    joy2 = 4'd5;
    chk("dead_col", int'(col), 635);

    Respawn = 1'b1; step(1); Respawn = 1'b0;
    chk("respawn_col", int'(col), 310);
    joy = 4'd9;
    step(72); chk("reach_400", int'(col), 400);

    Fire = 1'b1; exq.push_back('{400, 7});
    step(1); Fire = 1'b0;
    chk("req_lat", int'(req), 1);
    step(6); Ack = 1'b1;
    step(1); Ack = 1'b0;
    chk("req_drop", int'(req), 0);
    chk("moved_410", int'(col), 410);

    Fire = 1'b1; exq.push_back('{420, 1});
    step(8); chk("cool_block", int'(req), 0);
    step(1); chk("cool_refire", int'(req), 1);
    Ack = 1'b1; Fire = 1'b0;
    step(1); Ack = 1'b0;
    chk("req_drop2", int'(req), 0);

    step(2); chk("col_425", int'(col), 425);
    step(140); chk("col_600", int'(col), 600);

    Fire = 1'b1; exq.push_back('{600, 3});
    step(1); Fire = 1'b0;
    step(2); Respawn = 1'b1; joy = 4'd5;
    step(1); Respawn = 1'b0;
    chk("resp_tick_col", int'(col), 310);
    chk("resp_req", int'(req), 0);

    Fire = 1'b1; exq.push_back('{310, 1});
    step(1); Fire = 1'b0;
    chk("resp_idle", int'(req), 1);
    Ack = 1'b1;
    step(1); Ack = 1'b0; joy = 4'd9;
    step(2); chk("resp_cnt0", int'(col), 315);
    joy = 4'd5;

    step(8);
    Fire = 1'b1; exq.push_back('{315, 0});
    step(1); Fire = 1'b0;
    chk("pre_rst_req", int'(req), 1);
    step(1);
    #3 Reset = 1'b1;
    #1;
    chk("arst_row", int'(row), 350);
    chk("arst_col", int'(col), 310);
    chk("arst_req", int'(req), 0);
    chk("arst_scol", int'(scol), 0);
    step(1);
    Reset = 1'b0;
    step(1);
    chk("queue_empty", exq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
